// File: rtl/issue_unit_if.sv
// rtl/issue_unit_if.sv - ready/grant handshake and CDB reservation bundle between issue queues and issue unit
interface issue_unit_if #(
  parameter int RES_W = 8
);
  logic             IssueInt_Ready;
  logic             IssueLdSt_Ready;
  logic             IssueMult_Ready;
  logic             IssueDiv_Ready;
  logic             RB_Flush_Valid;
  logic             Issue_Int;
  logic             Issue_LdSt;
  logic             Issue_Mult;
  logic             Issue_Div;
  logic [RES_W-1:0] CDB_Resv;
  logic             Div_Busy;

  modport master (
    output IssueInt_Ready, IssueLdSt_Ready, IssueMult_Ready, IssueDiv_Ready, RB_Flush_Valid,
    input  Issue_Int, Issue_LdSt, Issue_Mult, Issue_Div, CDB_Resv, Div_Busy
  );

  modport slave (
    input  IssueInt_Ready, IssueLdSt_Ready, IssueMult_Ready, IssueDiv_Ready, RB_Flush_Valid,
    output Issue_Int, Issue_LdSt, Issue_Mult, Issue_Div, CDB_Resv, Div_Busy
  );
endinterface

// File: rtl/issue_unit.sv
// rtl/issue_unit.sv - single-port issue arbiter with CDB slot reservation and divider occupancy
module issue_unit #(
  parameter int INT_LAT  = 1,
  parameter int LDST_LAT = 1,
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 8,
  parameter int RES_W    = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  issue_unit_if.slave  bus
);
  localparam int               CNT_W = $clog2(DIV_LAT + 1);
  localparam logic [RES_W-1:0] ONE   = RES_W'(1);

  // A unit of latency L broadcasts L cycles after issue, i.e. it needs slot L-1 of the reservation.
  function automatic logic slot_taken(input logic [RES_W-1:0] resv, input int lat);
    return |(resv & (ONE << (lat - 1)));
  endfunction

  // After the shift, slot L-1 becomes slot L-2; latency-1 results land next cycle and need no claim.
  function automatic logic [RES_W-1:0] claim(input int lat);
    return (lat >= 2) ? (ONE << (lat - 2)) : '0;
  endfunction

  logic [RES_W-1:0] res_q, res_next;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_next;
  logic             lru_q, lru_next;

  logic int_ok, ldst_ok, mult_ok, div_ok;
  logic gate, alu_free;
  logic grant_int, grant_ldst, grant_mult, grant_div;

  always_comb begin
    int_ok  = bus.IssueInt_Ready  && !slot_taken(res_q, INT_LAT);
    ldst_ok = bus.IssueLdSt_Ready && !slot_taken(res_q, LDST_LAT);
    mult_ok = bus.IssueMult_Ready && !slot_taken(res_q, MULT_LAT);
    div_ok  = bus.IssueDiv_Ready  && !slot_taken(res_q, DIV_LAT) && (div_cnt_q == '0);

    gate       = !Rst && !bus.RB_Flush_Valid;
    grant_div  = gate && div_ok;
    grant_mult = gate && mult_ok && !div_ok;
    alu_free   = gate && !div_ok && !mult_ok;
    grant_int  = alu_free && int_ok  && (!ldst_ok || !lru_q);
    grant_ldst = alu_free && ldst_ok && (!int_ok  ||  lru_q);
  end

  always_comb begin
    res_next = (res_q >> 1)
             | ({RES_W{grant_int}}  & claim(INT_LAT))
             | ({RES_W{grant_ldst}} & claim(LDST_LAT))
             | ({RES_W{grant_mult}} & claim(MULT_LAT))
             | ({RES_W{grant_div}}  & claim(DIV_LAT));

    div_cnt_next = div_cnt_q;
    if (grant_div)
      div_cnt_next = CNT_W'(DIV_LAT - 1);
    else if (div_cnt_q != '0)
      div_cnt_next = div_cnt_q - CNT_W'(1);

    lru_next = lru_q;
    if (grant_int)
      lru_next = 1'b1;
    else if (grant_ldst)
      lru_next = 1'b0;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      res_q     <= '0;
      div_cnt_q <= '0;
      lru_q     <= 1'b0;
    end else begin
      res_q     <= res_next;
      div_cnt_q <= div_cnt_next;
      lru_q     <= lru_next;
    end
  end

  assign bus.Issue_Int  = grant_int;
  assign bus.Issue_LdSt = grant_ldst;
  assign bus.Issue_Mult = grant_mult;
  assign bus.Issue_Div  = grant_div;
  assign bus.CDB_Resv   = res_q;
  assign bus.Div_Busy   = (div_cnt_q != '0);
endmodule

// File: tb/tb_issue_unit.sv
// tb/tb_issue_unit.sv - randomized and directed checks of issue_unit against an absolute-time CDB model
module tb_issue_unit;
  localparam int RES_W = 8;
  localparam int L_INT = 1, L_LDST = 1, L_MULT = 4, L_DIV = 8;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  issue_unit_if #(.RES_W(RES_W)) bus ();

  issue_unit #(
    .INT_LAT(L_INT), .LDST_LAT(L_LDST), .MULT_LAT(L_MULT), .DIV_LAT(L_DIV), .RES_W(RES_W)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  // Model: the set of absolute cycles whose CDB slot is already owned, plus the cycle the divider frees up.
  bit taken[int];
  int div_free;
  bit lru_m;
  int cyc;
  int n_chk = 0;
  int n_fail = 0;

  function automatic bit taken_at(input int t);
    return taken.exists(t) ? taken[t] : 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit ri, input bit rl, input bit rm, input bit rd, input bit fl);
    bus.IssueInt_Ready  = ri;
    bus.IssueLdSt_Ready = rl;
    bus.IssueMult_Ready = rm;
    bus.IssueDiv_Ready  = rd;
    bus.RB_Flush_Valid  = fl;
  endtask

  // One clock cycle: drive, compare every output with the model, then advance the model.
  task automatic step(input bit ri, input bit rl, input bit rm, input bit rd, input bit fl,
                      output logic [3:0] g, output logic [7:0] rs, output logic bz);
    bit [3:0] e;
    bit [7:0] er;
    bit       eb, oi, ol, om, od;
    @(negedge Clk);
    drive(ri, rl, rm, rd, fl);
    #1;
    oi = ri && !fl && !taken_at(cyc + L_INT);
    ol = rl && !fl && !taken_at(cyc + L_LDST);
    om = rm && !fl && !taken_at(cyc + L_MULT);
    od = rd && !fl && !taken_at(cyc + L_DIV) && (cyc >= div_free);
    e = 4'b0000;
    if (od)              e[3] = 1'b1;
    else if (om)         e[2] = 1'b1;
    else if (oi && ol)   e[lru_m ? 1 : 0] = 1'b1;
    else if (oi)         e[0] = 1'b1;
    else if (ol)         e[1] = 1'b1;
    for (int k = 0; k < RES_W; k++) er[k] = taken_at(cyc + k + 1);
    eb = (cyc < div_free);

    g  = {bus.Issue_Div, bus.Issue_Mult, bus.Issue_LdSt, bus.Issue_Int};
    rs = bus.CDB_Resv;
    bz = bus.Div_Busy;
    chk("grants", 32'(g), 32'(e));
    chk("cdb_resv", 32'(rs), 32'(er));
    chk("div_busy", 32'(bz), 32'(eb));
    chk("one_grant", 32'($countones(g) <= 1), 32'd1);

    if (e[0]) begin taken[cyc + L_INT]  = 1'b1; lru_m = 1'b1; end
    if (e[1]) begin taken[cyc + L_LDST] = 1'b1; lru_m = 1'b0; end
    if (e[2]) taken[cyc + L_MULT] = 1'b1;
    if (e[3]) begin taken[cyc + L_DIV] = 1'b1; div_free = cyc + L_DIV; end
    cyc++;
  endtask

  // Asynchronous pulse mid-cycle; release lands just after a rising edge so the next step is cycle 0.
  task automatic do_reset();
    @(negedge Clk);
    #2;
    drive(1, 1, 1, 1, 0);
    Rst = 1'b1;
    #1;
    chk("rst_grants", 32'({bus.Issue_Div, bus.Issue_Mult, bus.Issue_LdSt, bus.Issue_Int}), 32'd0);
    chk("rst_resv", 32'(bus.CDB_Resv), 32'd0);
    chk("rst_busy", 32'(bus.Div_Busy), 32'd0);
    @(posedge Clk);
    #2;
    drive(0, 0, 0, 0, 0);
    Rst = 1'b0;
    taken.delete();
    lru_m = 1'b0;
    div_free = 0;
    cyc = 0;
  endtask

  logic [3:0] g;
  logic [7:0] rs;
  logic       bz;

  initial begin
    drive(0, 0, 0, 0, 0);
    Rst = 1'b1;
    cyc = 0; div_free = 0; lru_m = 1'b0;
    repeat (2) @(posedge Clk);
    do_reset();

    // Cold start with every queue ready, then the divider's 7 busy cycles and re-issue at +8.
    step(1, 1, 1, 1, 0, g, rs, bz);
    chk("lit_cold_div", 32'(g), 32'b1000);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 1, 0, g, rs, bz);
      if (i == 1) chk("lit_resv_40", 32'(rs), 32'h40);
      chk("lit_div_busy", 32'(bz), 32'(i <= 7));
      chk("lit_div_regrant", 32'(g[3]), 32'(i == 8));
    end

    // Mult at t steals the t+4 broadcast from Int held ready.
    do_reset();
    step(0, 0, 1, 0, 0, g, rs, bz);
    chk("lit_mult", 32'(g), 32'b0100);
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 0, 0, g, rs, bz);
      chk("lit_int_gap", 32'(g), (i == 3) ? 32'b0000 : 32'b0001);
      if (i == 3) chk("lit_resv_01", 32'(rs), 32'h01);
    end

    // Int/LdSt round robin.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0, 0, g, rs, bz);
      chk("lit_rr", 32'(g), (i % 2 == 0) ? 32'b0001 : 32'b0010);
    end

    // Flush the cycle after a Mult issue: nothing granted, reservation still shifts, lru untouched.
    do_reset();
    step(0, 0, 1, 0, 0, g, rs, bz);
    step(1, 1, 1, 1, 1, g, rs, bz);
    chk("lit_flush_grants", 32'(g), 32'd0);
    chk("lit_flush_resv", 32'(rs), 32'h04);
    step(1, 1, 0, 0, 0, g, rs, bz);
    chk("lit_flush_shift", 32'(rs), 32'h02);
    chk("lit_flush_lru", 32'(g), 32'b0001);

    // Reset while the divider is busy and the CDB holds reservations.
    do_reset();
    step(0, 0, 1, 0, 0, g, rs, bz);
    step(0, 0, 0, 1, 0, g, rs, bz);
    step(0, 0, 0, 0, 0, g, rs, bz);
    chk("lit_pre_rst_resv", 32'(rs), 32'h42);
    chk("lit_pre_rst_busy", 32'(bz), 32'd1);
    do_reset();
    step(0, 0, 0, 1, 0, g, rs, bz);
    chk("lit_post_rst_div", 32'(g), 32'b1000);

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 8, g, rs, bz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
